pif_led_mode: RTL and testbench
===============================

# pif_led_mode

Mode controller downstream of the PIF LED flasher: consumes the flasher's active-low red/green outputs and drives the board LED pins. A host register write selects the LED behaviour: off, flasher passthrough, solid colour, red/green alternate blink, or a counted red pulse burst that returns to the previous mode. The block runs in the flasher's oscillator domain and has its own tick prescaler, so blink rates are independent of the flasher's tick.

## Interface

Parameters:
- TICK_DIV, default 8: Clk cycles per internal tick; legal values ≥ 2.
- BLINK_TICKS, default 4: ticks per blink/pulse half-period; legal values ≥ 1.

Ports:
- Clk  in  1  oscillator clock (same net as flasher xclk).
- Rst  in  1  synchronous reset, active-high.
- WrEn  in  1  host write strobe.
- WrData  in  8  [2:0] mode code, [7:4] pulse count, [3] ignored.
- WrRdy  out  1  write accepted when WrEn & WrRdy at a rising edge.
- FlashRedN  in  1  flasher red output, active-low.
- FlashGreenN  in  1  flasher green output, active-low.
- LedRedN  out  1  red LED pin, active-low, registered.
- LedGreenN  out  1  green LED pin, active-low, registered.
- Mode  out  3  current effective mode code, registered.

## Operation

- Mode codes: 0 OFF, 1 FLASH, 2 SOLID_RED, 3 SOLID_GREEN, 4 BLINK, 5 PULSE. Codes 6 and 7 are stored and behave as OFF.
- Output by mode:
  - OFF: both outputs high.
  - FLASH: LedRedN = FlashRedN, LedGreenN = FlashGreenN.
  - SOLID_RED: LedRedN low, LedGreenN high.
  - SOLID_GREEN: LedGreenN low, LedRedN high.
  - BLINK: phase 0 lights red only; phase 1 lights green only; the phase toggles every BLINK_TICKS ticks.
  - PULSE: green is always high. Red runs N cycles of (ON for BLINK_TICKS ticks, OFF for BLINK_TICKS ticks).
- Prescaler: a down-counter loaded with TICK_DIV-1. It pulses tick for one cycle when it reaches 0, then reloads the same cycle.
- Tick counter: counts 0..BLINK_TICKS-1 on tick and produces the half-period event on wrap.
- Any accepted write:
  - reloads the prescaler;
  - clears the tick counter;
  - sets the blink/pulse phase to 0, so each mode starts with red ON or phase 0.
- PULSE handling:
  - A PULSE write saves the current Mode into a return register.
  - N = WrData[7:4]; N = 0 means 16.
  - The pulse counter decrements at the end of each OFF half-period.
  - After the last OFF half-period, Mode restores to the saved mode, and the phase, prescaler and tick counter restart as on a write.
- WrRdy:
  - WrRdy is low for the whole PULSE sequence, and WrEn is ignored while low.
  - WrRdy is high in every other mode.
- Reset values:
  - Mode = 1 (FLASH), WrRdy = 1.
  - LedRedN = 1, LedGreenN = 1.
  - Prescaler = TICK_DIV-1; tick counter, phase, pulse counter and return register = 0.

## Timing

- An accepted write at edge E updates Mode at E.
- LED outputs reflect the new mode from edge E+1, because outputs are registered from Mode and state.
- FLASH passthrough latency is 1 Clk from FlashRedN/FlashGreenN to the LED pins.
- Half-period = TICK_DIV × BLINK_TICKS Clk cycles, measured from the write edge to the first toggle edge of the internal phase.
- PULSE total duration = 2 × N × TICK_DIV × BLINK_TICKS cycles.
  - WrRdy falls at E.
  - WrRdy rises at the same edge that restores Mode.
- Simultaneous events:
  - A write coincident with a tick: the write wins and the tick is discarded.
  - Rst coincident with WrEn: reset wins and the write is dropped.
- Rst asserted mid-PULSE aborts the burst:
  - Mode = FLASH and WrRdy = 1 after the reset edge;
  - the return register is cleared.
- A PULSE written with saved mode PULSE cannot occur, since WrRdy is low during PULSE.

## Test plan

All scenarios use TICK_DIV = 4 and BLINK_TICKS = 2, so a half-period is 8 cycles.

- **Reset:** Rst for 2 cycles, FlashRedN toggling.
  - Mode = 1 and WrRdy = 1 after reset.
  - LedRedN follows FlashRedN delayed by 1 cycle from the first post-reset edge.
- **BLINK:** write 0x04.
  - Mode = 4 at E; from E+1, LedRedN = 0 and LedGreenN = 1.
  - The outputs swap every 8 cycles; check 4 toggles.
- **PULSE:** write 0x35 while in SOLID_GREEN (0x03).
  - WrRdy is low for 48 cycles, and red goes low/high 3 times with 8-cycle halves.
  - Mode then returns to 3 and LedGreenN = 0 one cycle later.
- **PULSE, count 0:** write 0x05 from OFF.
  - 16 pulses over 256 cycles, then Mode = 0.
  - WrEn pulsed mid-burst with 0x02 is ignored; Mode stays 5 until the end of the burst.
- **Reset mid-PULSE:** assert Rst at cycle 20 of a PULSE.
  - Mode = 1, WrRdy = 1, both LEDs high after the reset edge.
  - Mode does not fall back to the previously saved mode.
- **Write-vs-tick and unused codes:** write 0x04 exactly on a prescaler tick.
  - The first toggle is still 8 cycles after the write.
  - Writing 0x07 gives Mode = 7 with both LEDs high.

Source files
------------

// File: rtl/pif_led_mode.sv
// rtl/pif_led_mode.sv - LED mode controller downstream of the PIF LED flasher
//
// Ports:
//   Clk          oscillator clock (same net as flasher xclk)
//   Rst          synchronous reset, active-high
//   WrEn/WrData  host write: [2:0] mode code, [7:4] pulse count (0 = 16), [3] unused
//   WrRdy        write accepted when WrEn & WrRdy; low for the whole PULSE burst
//   FlashRedN    flasher red output, active-low
//   FlashGreenN  flasher green output, active-low
//   LedRedN      red LED pin, active-low, registered
//   LedGreenN    green LED pin, active-low, registered
//   Mode         current effective mode code, registered
module pif_led_mode #(
    parameter int TICK_DIV    = 8,
    parameter int BLINK_TICKS = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       WrEn,
    input  logic [7:0] WrData,
    output logic       WrRdy,
    input  logic       FlashRedN,
    input  logic       FlashGreenN,
    output logic       LedRedN,
    output logic       LedGreenN,
    output logic [2:0] Mode
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(BLINK_TICKS - 1);

    localparam logic [2:0] M_OFF         = 3'd0;
    localparam logic [2:0] M_FLASH       = 3'd1;
    localparam logic [2:0] M_SOLID_RED   = 3'd2;
    localparam logic [2:0] M_SOLID_GREEN = 3'd3;
    localparam logic [2:0] M_BLINK       = 3'd4;
    localparam logic [2:0] M_PULSE       = 3'd5;

    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          phase_q, phase_d;
    logic [4:0]    pcnt_q, pcnt_d;
    logic [2:0]    ret_q, ret_d;
    logic [2:0]    mode_d;
    logic          led_red_d, led_green_d;
    logic          wr_acc, tick, half, restart;
    logic          wr_data_unused;

    assign wr_data_unused = WrData[3];

    // Only a PULSE burst holds Mode at 5, so readiness is a decode of Mode.
    assign WrRdy  = (Mode != M_PULSE);
    assign wr_acc = WrEn & WrRdy;
    assign tick   = (presc_q == '0);
    // A write on the same edge swallows the tick, so no half event then.
    assign half   = tick && (tcnt_q == TICK_LAST) && !wr_acc;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            presc_q   <= PRESC_LOAD;
            tcnt_q    <= '0;
            phase_q   <= 1'b0;
            pcnt_q    <= '0;
            ret_q     <= '0;
            Mode      <= M_FLASH;
            LedRedN   <= 1'b1;
            LedGreenN <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            tcnt_q    <= tcnt_d;
            phase_q   <= phase_d;
            pcnt_q    <= pcnt_d;
            ret_q     <= ret_d;
            Mode      <= mode_d;
            LedRedN   <= led_red_d;
            LedGreenN <= led_green_d;
        end
    end

    // Next-state logic
    always_comb begin
        presc_d = tick ? PRESC_LOAD : presc_q - PW'(1);
        tcnt_d  = tcnt_q;
        if (tick) begin
            tcnt_d = (tcnt_q == TICK_LAST) ? '0 : tcnt_q + TW'(1);
        end
        phase_d = phase_q ^ half;
        pcnt_d  = pcnt_q;
        ret_d   = ret_q;
        mode_d  = Mode;
        restart = 1'b0;

        // Phase 1 is the OFF half of a pulse; its end closes one pulse.
        if (Mode == M_PULSE && half && phase_q) begin
            pcnt_d = pcnt_q - 5'd1;
            if (pcnt_q == 5'd1) begin
                mode_d  = ret_q;
                restart = 1'b1;
            end
        end

        if (wr_acc) begin
            mode_d  = WrData[2:0];
            restart = 1'b1;
            if (WrData[2:0] == M_PULSE) begin
                ret_d  = Mode;
                pcnt_d = {(WrData[7:4] == 4'd0), WrData[7:4]};
            end
        end

        if (restart) begin
            presc_d = PRESC_LOAD;
            tcnt_d  = '0;
            phase_d = 1'b0;
        end
    end

    // Output logic (registered on the next edge)
    always_comb begin
        led_red_d   = 1'b1;
        led_green_d = 1'b1;
        case (Mode)
            M_FLASH: begin
                led_red_d   = FlashRedN;
                led_green_d = FlashGreenN;
            end
            M_SOLID_RED:   led_red_d   = 1'b0;
            M_SOLID_GREEN: led_green_d = 1'b0;
            M_BLINK: begin
                led_red_d   = phase_q;
                led_green_d = ~phase_q;
            end
            M_PULSE:       led_red_d   = phase_q;
            default: begin
                led_red_d   = 1'b1;
                led_green_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pif_led_mode.sv
// tb/tb_pif_led_mode.sv - self-checking bench for pif_led_mode
module tb_pif_led_mode;

    localparam int TD   = 4;
    localparam int BT   = 2;
    localparam int HALF = TD * BT;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       WrEn = 1'b0;
    logic [7:0] WrData = 8'h00;
    logic       FlashRedN = 1'b1;
    logic       FlashGreenN = 1'b1;
    logic       WrRdy;
    logic       LedRedN;
    logic       LedGreenN;
    logic [2:0] Mode;

    pif_led_mode #(.TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .WrEn       (WrEn),
        .WrData     (WrData),
        .WrRdy      (WrRdy),
        .FlashRedN  (FlashRedN),
        .FlashGreenN(FlashGreenN),
        .LedRedN    (LedRedN),
        .LedGreenN  (LedGreenN),
        .Mode       (Mode)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode, return mode, pulse count and the number of
    // edges since the last epoch (write, restore or reset).
    int   m_mode = 1;
    int   m_ret  = 0;
    int   m_n    = 0;
    int   m_t    = 0;
    logic e_red  = 1'b1;
    logic e_green = 1'b1;
    logic cur_fr = 1'b1;
    logic cur_fg = 1'b1;

    typedef struct packed {
        logic       wen;
        logic [7:0] d;
        logic       fr;
        logic       fg;
        logic [2:0] mode;
        logic       red;
        logic       green;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int ph;
        if (Rst) begin
            m_mode  = 1;
            m_ret   = 0;
            m_t     = 0;
            e_red   = 1'b1;
            e_green = 1'b1;
        end else begin
            ph = (m_t / HALF) % 2;
            case (m_mode)
                1: begin e_red = FlashRedN; e_green = FlashGreenN; end
                2: begin e_red = 1'b0;      e_green = 1'b1;        end
                3: begin e_red = 1'b1;      e_green = 1'b0;        end
                4: begin e_red = (ph == 1); e_green = (ph == 0);   end
                5: begin e_red = (ph == 1); e_green = 1'b1;        end
                default: begin e_red = 1'b1; e_green = 1'b1; end
            endcase
            if (WrEn && m_mode != 5) begin
                if (WrData[2:0] == 3'd5) begin
                    m_ret = m_mode;
                    m_n   = (WrData[7:4] == 4'd0) ? 16 : int'(WrData[7:4]);
                end
                m_mode = int'(WrData[2:0]);
                m_t    = 0;
            end else begin
                m_t++;
                if (m_mode == 5 && m_t == 2 * m_n * HALF) begin
                    m_mode = m_ret;
                    m_t    = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic wen, input logic [7:0] d,
                       input logic fr, input logic fg);
        Rst = rst; WrEn = wen; WrData = d; FlashRedN = fr; FlashGreenN = fg;
        model_edge();
        @(posedge Clk);
        #1;
        check("model_mode", Mode, m_mode);
        check("model_wrrdy", WrRdy, (m_mode != 5));
        check("model_led_red", LedRedN, e_red);
        check("model_led_green", LedGreenN, e_green);
        Rst = 1'b0; WrEn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, cur_fr, cur_fg);
    endtask

    task automatic wr(input logic [7:0] d);
        cyc(1'b0, 1'b1, d, cur_fr, cur_fg);
    endtask

    // Checks blink/pulse red phase for k = 1..n edges after a write edge.
    task automatic check_blink(input string name, input int n);
        for (int k = 1; k <= n; k++) begin
            idle(1);
            check(name, LedRedN, ((k - 1) / HALF) % 2);
            check({name, "_green"}, LedGreenN, 1 - ((k - 1) / HALF) % 2);
        end
    endtask

    task automatic run_pulse(input int inject_at, output int lows, output int falls,
                             output int mode_drop);
        logic prev;
        int   n;
        lows = 1; falls = 0; mode_drop = 0; n = 0;
        prev = LedRedN;
        while (WrRdy == 1'b0 && n < 600) begin
            n++;
            if (n == inject_at) cyc(1'b0, 1'b1, 8'h02, cur_fr, cur_fg);
            else idle(1);
            if (WrRdy == 1'b0) begin
                lows++;
                if (Mode != 3'd5) mode_drop++;
            end
            if (prev == 1'b1 && LedRedN == 1'b0) falls++;
            prev = LedRedN;
        end
    endtask

    initial begin
        int lows, falls, drop, bad_mode;

        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 8'h03, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 8'h07, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 8'hF6, 1'b0, 1'b0, 3'd6, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 8'h08, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 8'h01, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'h04, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};

        // Reset with FlashRedN toggling, then passthrough latency
        cyc(1'b1, 1'b1, 8'h03, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check("reset_mode", Mode, 3'd1);
        check("reset_wrrdy", WrRdy, 1'b1);
        check("reset_led_red", LedRedN, 1'b1);
        check("reset_led_green", LedGreenN, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 8'h00, logic'(i % 2), 1'b1);
            check("flash_follow", LedRedN, i % 2);
        end

        // Table-driven single-cycle vectors
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, tbl[i].wen, tbl[i].d, tbl[i].fr, tbl[i].fg);
            check("tbl_mode", Mode, tbl[i].mode);
            check("tbl_wrrdy", WrRdy, 1'b1);
            check("tbl_led_red", LedRedN, tbl[i].red);
            check("tbl_led_green", LedGreenN, tbl[i].green);
        end

        // BLINK: four toggles at 8-cycle spacing
        wr(8'h04);
        check("blink_mode", Mode, 3'd4);
        check_blink("blink_red", 4 * HALF + 1);

        // PULSE x3 from SOLID_GREEN
        wr(8'h03);
        idle(2);
        wr(8'h35);
        check("pulse_wrrdy_fall", WrRdy, 1'b0);
        run_pulse(-1, lows, falls, drop);
        check("pulse_rdy_low_cycles", lows, 2 * 3 * HALF);
        check("pulse_red_falls", falls, 3);
        check("pulse_mode_held", drop, 0);
        check("pulse_restore_mode", Mode, 3'd3);
        idle(1);
        check("pulse_restore_green", LedGreenN, 1'b0);

        // PULSE count 0 (16 pulses) from OFF, write ignored mid-burst
        wr(8'h00);
        wr(8'h05);
        run_pulse(100, lows, falls, drop);
        check("pulse16_rdy_low_cycles", lows, 2 * 16 * HALF);
        check("pulse16_red_falls", falls, 16);
        check("pulse16_ignored_write", drop, 0);
        check("pulse16_restore_mode", Mode, 3'd0);

        // Reset mid-PULSE aborts the burst
        wr(8'h02);
        wr(8'h05);
        idle(19);
        cyc(1'b1, 1'b1, 8'h03, cur_fr, cur_fg);
        check("abort_mode", Mode, 3'd1);
        check("abort_wrrdy", WrRdy, 1'b1);
        check("abort_led_red", LedRedN, 1'b1);
        check("abort_led_green", LedGreenN, 1'b1);
        bad_mode = 0;
        for (int i = 0; i < 300; i++) begin
            idle(1);
            if (Mode != 3'd1) bad_mode++;
        end
        check("abort_no_fallback", bad_mode, 0);

        // Write exactly on a prescaler tick: tick discarded
        wr(8'h02);
        idle(TD - 1);
        wr(8'h04);
        check_blink("tickwr_red", 2 * HALF + 1);
        wr(8'h07);
        check("code7_mode", Mode, 3'd7);
        idle(1);
        check("code7_led_red", LedRedN, 1'b1);
        check("code7_led_green", LedGreenN, 1'b1);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            cur_fr = logic'($urandom_range(0, 1));
            cur_fg = logic'($urandom_range(0, 1));
            cyc(logic'($urandom_range(0, 499) == 0), logic'($urandom_range(0, 15) == 0),
                8'($urandom), cur_fr, cur_fg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
